// File: rtl/wt_pkg.sv
// Shared definitions for the wavetable voice engine: ROM geometry, silence level
// and the scan state encoding.
package wt_pkg;

    localparam int WFM_IDX_W    = 8;
    localparam int SAMPLE_IDX_W = 6;
    localparam int SAMPLE_W     = 8;

    localparam logic [SAMPLE_W-1:0] SILENCE = 8'h80;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

endpackage

// File: rtl/wt_interp.sv
// Combinational linear interpolation between two adjacent unsigned samples,
// weighted by a 4-bit fraction of the distance from a towards b.
module wt_interp
    import wt_pkg::*;
(
    input  logic [SAMPLE_W-1:0] a,
    input  logic [SAMPLE_W-1:0] b,
    input  logic [3:0]          frac,
    output logic [SAMPLE_W-1:0] y
);

    logic signed [8:0]  d;
    logic signed [13:0] prod;
    logic signed [13:0] sum;

    // Clamp into the unsigned sample range; the floor shift keeps the sum
    // between a and b, so this only guards against future width changes.
    function automatic logic [SAMPLE_W-1:0] sat_u8(input logic signed [13:0] x);
        logic [SAMPLE_W-1:0] r;
        if (x < 14'sd0)
            r = '0;
        else if (x > 14'sd255)
            r = '1;
        else
            r = x[SAMPLE_W-1:0];
        return r;
    endfunction

    assign d    = $signed({1'b0, b}) - $signed({1'b0, a});
    assign prod = 14'(d) * 14'($signed({1'b0, frac}));
    assign sum  = $signed({6'b0, a}) + (prod >>> 4);
    assign y    = sat_u8(sum);

endmodule

// File: rtl/wt_voice_engine.sv
// Time-multiplexed wavetable oscillator: each sample_tick scans all voices,
// reads one ROM sample per gated voice and emits one sample per voice.
// Optional linear interpolation via port B: define WT_VOICE_ENGINE_INTERP_EN.
module wt_voice_engine
    import wt_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int VOICE_W    = 3,
    parameter int PHASE_W    = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_tick,
    input  logic                    cfg_we,
    input  logic [VOICE_W-1:0]      cfg_voice,
    input  logic [PHASE_W-1:0]      cfg_step,
    input  logic [WFM_IDX_W-1:0]    cfg_wfm,
    input  logic                    cfg_gate,
    input  logic                    cfg_phase_rst,
    output logic                    rom_re_a,
    output logic [SAMPLE_IDX_W-1:0] rom_addr_a_sample,
    output logic [WFM_IDX_W-1:0]    rom_addr_a_wfm,
    input  logic [SAMPLE_W-1:0]     rom_data_a,
    output logic                    rom_re_b,
    output logic [SAMPLE_IDX_W-1:0] rom_addr_b_sample,
    output logic [WFM_IDX_W-1:0]    rom_addr_b_wfm,
    input  logic [SAMPLE_W-1:0]     rom_data_b,
    output logic                    out_valid,
    output logic [VOICE_W-1:0]      out_voice,
    output logic [SAMPLE_W-1:0]     out_sample,
    output logic                    busy,
    output logic                    overrun
);

    state_t state, state_nx;
    logic [VOICE_W-1:0] v;
    logic               last_voice;

    logic [PHASE_W-1:0]   phase [NUM_VOICES];
    logic [PHASE_W-1:0]   step  [NUM_VOICES];
    logic [WFM_IDX_W-1:0] wfm   [NUM_VOICES];
    logic                 gate  [NUM_VOICES];

    logic                    issue_re;
    logic [SAMPLE_IDX_W-1:0] cur_sample;
    logic [SAMPLE_IDX_W-1:0] addr_sample_p1;
    logic [WFM_IDX_W-1:0]    addr_wfm_p1;
    logic                    gate_p1;
    logic [SAMPLE_W-1:0]     lerp;

    logic                vld_p2;
    logic [VOICE_W-1:0]  voice_p2;
    logic [SAMPLE_W-1:0] sample_p2;

    assign last_voice = (v == VOICE_W'(NUM_VOICES - 1));
    assign cur_sample = phase[v][PHASE_W-1 -: SAMPLE_IDX_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sample_tick) state_nx = ISSUE;
            ISSUE:   state_nx = CAPTURE;
            CAPTURE: state_nx = last_voice ? IDLE : ISSUE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        issue_re = (state == ISSUE) && gate[v];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v       <= '0;
            overrun <= 1'b0;
        end else begin
            if (state == IDLE && sample_tick)
                v <= '0;
            else if (state == CAPTURE && !last_voice)
                v <= v + VOICE_W'(1);
            if (sample_tick && state != IDLE)
                overrun <= 1'b1;
        end
    end

    // A write landing on a voice's ISSUE cycle only lands at the edge that ends it,
    // so that ISSUE still reads the old configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                step[i] <= '0;
                wfm[i]  <= '0;
                gate[i] <= 1'b0;
            end
        end else if (cfg_we) begin
            step[cfg_voice] <= cfg_step;
            wfm[cfg_voice]  <= cfg_wfm;
            gate[cfg_voice] <= cfg_gate;
        end
    end

    // The phase clear is written last so it beats a coincident accumulate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_VOICES; i++)
                phase[i] <= '0;
        end else begin
            if (state == CAPTURE && gate_p1)
                phase[v] <= phase[v] + step[v];
            if (cfg_we && cfg_phase_rst)
                phase[cfg_voice] <= '0;
        end
    end

    // ---- ISSUE -> CAPTURE boundary ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_sample_p1 <= '0;
            addr_wfm_p1    <= '0;
            gate_p1        <= 1'b0;
        end else begin
            if (issue_re) begin
                addr_sample_p1 <= cur_sample;
                addr_wfm_p1    <= wfm[v];
            end
            if (state == ISSUE)
                gate_p1 <= gate[v];
        end
    end

    assign rom_re_a          = issue_re;
    assign rom_addr_a_sample = issue_re ? cur_sample : addr_sample_p1;
    assign rom_addr_a_wfm    = issue_re ? wfm[v]     : addr_wfm_p1;

`ifdef WT_VOICE_ENGINE_INTERP_EN
    logic [3:0] frac;

    // Phase is still the pre-increment value during CAPTURE.
    assign frac = phase[v][PHASE_W-7 -: 4];

    wt_interp u_interp (
        .a    (rom_data_a),
        .b    (rom_data_b),
        .frac (frac),
        .y    (lerp)
    );

    assign rom_re_b          = rom_re_a;
    assign rom_addr_b_sample = rom_addr_a_sample + SAMPLE_IDX_W'(1);
    assign rom_addr_b_wfm    = rom_addr_a_wfm;
`else
    logic unused_rom_b;

    assign unused_rom_b      = ^rom_data_b;
    assign lerp              = rom_data_a;
    assign rom_re_b          = 1'b0;
    assign rom_addr_b_sample = '0;
    assign rom_addr_b_wfm    = '0;
`endif

    // ---- CAPTURE -> output boundary ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2    <= 1'b0;
            voice_p2  <= '0;
            sample_p2 <= SILENCE;
        end else begin
            vld_p2 <= (state == CAPTURE);
            if (state == CAPTURE) begin
                voice_p2  <= v;
                sample_p2 <= gate_p1 ? lerp : SILENCE;
            end
        end
    end

    assign out_valid  = vld_p2;
    assign out_voice  = voice_p2;
    assign out_sample = sample_p2;

endmodule
